// File: rtl/array_mult_pipe.sv
// -----------------------------------------------------------------------------
// array_mult_pipe
//
// N-lane signed fixed-point multiplier with valid/ready flow control.
// Each accepted operand vector produces one result vector LAT = MULT_STAGES + 1
// cycles later: MULT_STAGES registered multiply stages followed by one
// round/output stage. Lanes are fully independent.
//
// Per lane:  P = a * b                    (full 2W-bit signed product)
//            R = P[2W-1:F] (+ P[F-1] when ROUND_MODE = 1 and F > 0)
//            result = R[W-1:0]           (wrap build)
//            result = clamp(R), ovf = 1  (saturating build)
//
// Optional feature macro: ARRAY_MULT_PIPE_SAT_EN
//   defined   -> out-of-range R clamps to the nearest W-bit bound, ovf[k] = 1
//   undefined -> R wraps to its low W bits, ovf is tied to 0
//
// Ports:
//   clk        in   1     clock, all state on rising edge
//   reset_n    in   1     asynchronous active-low reset
//   in_valid   in   1     operand vector valid
//   in_ready   out  1     block accepts operands this cycle
//   dataa      in   N*W   lane k operand a at [k*W +: W]
//   datab      in   N*W   lane k operand b at [k*W +: W]
//   out_valid  out  1     result vector valid
//   out_ready  in   1     downstream accepts result
//   result     out  N*W   lane k result at [k*W +: W]
//   ovf        out  N     per-lane overflow flag, aligned with result
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and data stable until the transfer. The whole
// pipeline advances in lockstep when adv = !out_valid || out_ready; in_ready is
// adv itself, so a stalled output (out_valid && !out_ready) freezes every stage
// and blocks new operands. Bubbles are carried, never collapsed.
// -----------------------------------------------------------------------------
module array_mult_pipe #(
  parameter int N           = 4,
  parameter int W           = 36,
  parameter int F           = 18,
  parameter int MULT_STAGES = 2,
  parameter int ROUND_MODE  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*W-1:0]   dataa,
  input  logic [N*W-1:0]   datab,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*W-1:0]   result,
  output logic [N-1:0]     ovf
);

  // Full product width and the width of the rounded value R. R carries one
  // extra bit above P[2W-1:F] so the rounding increment can never wrap.
  localparam int PW = 2 * W;
  localparam int RW = 2 * W - F + 1;

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic [PW-1:0]          prod_d [MULT_STAGES][N];
  logic [PW-1:0]          prod_q [MULT_STAGES][N];
  logic [MULT_STAGES-1:0] vld_d;
  logic [MULT_STAGES-1:0] vld_q;
  logic                   out_valid_d;
  logic                   out_valid_q;
  logic [N*W-1:0]         result_d;
  logic [N*W-1:0]         result_q;

  logic                   adv;
  logic                   accept;

  // Per-lane combinational values
  logic [PW-1:0]          mul      [N];
  logic [W-1:0]           lane_res [N];

  assign adv       = !out_valid_q || out_ready;
  assign accept    = in_valid && adv;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;

  // ---------------------------------------------------------------------------
  // Lane datapath: product into stage 0, rounding/output from the last stage
  // ---------------------------------------------------------------------------
`ifdef ARRAY_MULT_PIPE_SAT_EN
  logic [N-1:0] lane_ovf;
`endif

  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [W-1:0]  a_k;
    logic [W-1:0]  b_k;
    logic [PW-1:0] p_last;
    logic          round_bit;
    logic [RW-1:0] r_k;
    logic          lane_unused;

    assign a_k = dataa[k*W +: W];
    assign b_k = datab[k*W +: W];

    // Both operands sign-extended to 2W bits: the low 2W bits of the unsigned
    // product are then exactly the two's-complement signed product.
    assign mul[k] = {{W{a_k[W-1]}}, a_k} * {{W{b_k[W-1]}}, b_k};

    assign p_last = prod_q[MULT_STAGES-1][k];

    // With F = 0 there is no bit below the kept field, so nothing to round.
    if (ROUND_MODE != 0 && F > 0) begin : g_round
      assign round_bit = p_last[F-1];
    end else begin : g_trunc
      assign round_bit = 1'b0;
    end

    assign r_k = {p_last[PW-1], p_last[PW-1:F]} + {{(RW-1){1'b0}}, round_bit};

`ifdef ARRAY_MULT_PIPE_SAT_EN
    // R fits in W signed bits only when its bits [RW-1:W-1] are all equal.
    logic [RW-W:0] hi_bits;
    assign hi_bits     = r_k[RW-1:W-1];
    assign lane_ovf[k] = (|hi_bits) && !(&hi_bits);
    assign lane_res[k] = !lane_ovf[k] ? r_k[W-1:0] :
                         r_k[RW-1]    ? {1'b1, {(W-1){1'b0}}} :
                                        {1'b0, {(W-1){1'b1}}};
`else
    assign lane_res[k] = r_k[W-1:0];
`endif

    // Fraction bits below the rounding bit and the wrapped-away high bits of
    // R are deliberately discarded.
    assign lane_unused = ^{p_last, r_k};
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    prod_d      = prod_q;
    vld_d       = vld_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;

    if (adv) begin
      vld_d[0] = accept;
      // Only load new operands' products on a real transfer; bubbles keep
      // stale data, which is harmless because it travels with valid = 0.
      if (accept) begin
        for (int k = 0; k < N; k++) begin
          prod_d[0][k] = mul[k];
        end
      end
      for (int s = 1; s < MULT_STAGES; s++) begin
        vld_d[s]  = vld_q[s-1];
        prod_d[s] = prod_q[s-1];
      end

      out_valid_d = vld_q[MULT_STAGES-1];
      // The output register only updates for a valid vector, so result keeps
      // the last delivered value across bubbles.
      if (vld_q[MULT_STAGES-1]) begin
        for (int k = 0; k < N; k++) begin
          result_d[k*W +: W] = lane_res[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < MULT_STAGES; s++) begin
        for (int k = 0; k < N; k++) begin
          prod_q[s][k] <= '0;
        end
      end
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      prod_q      <= prod_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow flags
  // ---------------------------------------------------------------------------
`ifdef ARRAY_MULT_PIPE_SAT_EN
  logic [N-1:0] ovf_d;
  logic [N-1:0] ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    if (adv && vld_q[MULT_STAGES-1]) begin
      ovf_d = lane_ovf;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = '0;
`endif

endmodule

// File: tb/tb_array_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_array_mult_pipe
//
// Self-checking bench for array_mult_pipe at its default configuration
// (N=4, W=36, F=18, MULT_STAGES=2, ROUND_MODE=1). Expected values come from a
// behavioural model that forms the signed product, shifts and rounds with
// plain wide arithmetic, and clamps by numeric comparison when
// ARRAY_MULT_PIPE_SAT_EN is defined.
// -----------------------------------------------------------------------------
module tb_array_mult_pipe;

  localparam int N   = 4;
  localparam int W   = 36;
  localparam int F   = 18;
  localparam int MS  = 2;
  localparam int RM  = 1;
  localparam int LAT = MS + 1;
  localparam int VW  = N * W;
  localparam int NV  = 10000;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [VW-1:0] dataa     = '0;
  logic [VW-1:0] datab     = '0;
  logic          in_ready;
  logic          out_valid;
  logic [VW-1:0] result;
  logic [N-1:0]  ovf;

  int checks = 0;
  int passed = 0;

  // Scoreboard entries are {ovf, result}.
  logic [VW+N-1:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Clock / DUT
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  array_mult_pipe #(
    .N(N), .W(W), .F(F), .MULT_STAGES(MS), .ROUND_MODE(RM)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dataa    (dataa),
    .datab    (datab),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .ovf      (ovf)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [W:0] model_lane(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] pa, pb, p;
    logic signed [2*W:0]   r, hi, lo;
    logic                  ov;
    logic [W-1:0]          v;
    pa = {{W{a[W-1]}}, a};
    pb = {{W{b[W-1]}}, b};
    p  = pa * pb;
    r  = {p[2*W-1], p};
    r  = r >>> F;
    if (RM != 0) r = r + {{(2*W){1'b0}}, p[F-1]};
    hi = {{(W+2){1'b0}}, {(W-1){1'b1}}};
    lo = ~hi;
    ov = 1'b0;
    v  = r[W-1:0];
`ifdef ARRAY_MULT_PIPE_SAT_EN
    if (r > hi) begin
      ov = 1'b1;
      v  = hi[W-1:0];
    end else if (r < lo) begin
      ov = 1'b1;
      v  = lo[W-1:0];
    end
`endif
    return {ov, v};
  endfunction

  function automatic logic [VW+N-1:0] model_vec(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    logic [N-1:0]  o;
    logic [W:0]    l;
    for (int k = 0; k < N; k++) begin
      l            = model_lane(a[k*W +: W], b[k*W +: W]);
      r[k*W +: W]  = l[W-1:0];
      o[k]         = l[W];
    end
    return {o, r};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [63:0]         x;
    logic [31:0]         su;
    logic signed [W-1:0] t;
    logic [W-1:0]        v;
    x = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: v = x[W-1:0];
      1: begin
        su = $urandom_range(0, 2097152) - 32'd1048576;
        v  = {{(W-32){su[31]}}, su};
      end
      2: begin
        case ($urandom_range(0, 5))
          0:       v = {1'b0, {(W-1){1'b1}}};
          1:       v = {1'b1, {(W-1){1'b0}}};
          2:       v = '0;
          3:       v = '1;
          4:       v = W'(1) << F;
          default: v = W'(1) << (F - 1);
        endcase
      end
      default: begin
        t = x[W-1:0];
        v = t >>> $urandom_range(4, 24);
      end
    endcase
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = rand_operand();
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one vector in with out_ready held high, wait for its result.
  // lat is the number of rising edges from the accept edge to out_valid
  // (-1 if it never arrives).
  // ---------------------------------------------------------------------------
  task automatic run_one(input logic [VW-1:0] a, input logic [VW-1:0] b,
                         output logic [VW-1:0] res, output logic [N-1:0] o,
                         output int lat);
    int tries;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    dataa     = a;
    datab     = b;
    out_ready = 1'b1;
    tries     = 0;
    @(negedge clk);
    while (!in_ready && tries < 10) begin
      @(negedge clk);
      tries++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    o   = ovf;
    if (!out_valid) lat = -1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n   = 1'b0;
    out_ready = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    checks++; if (result !== '0) $display("FAIL reset_result got=%h exp=0", result); else passed++;
    checks++; if (ovf !== '0) $display("FAIL reset_ovf got=%b exp=0", ovf); else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
  endtask

  task automatic test_basic();
    logic [VW-1:0]   a, b, res, e;
    logic [N-1:0]    o;
    logic [VW+N-1:0] m;
    int              lat;
    a = '0; b = '0; e = '0;
    a[W-1:0] = 36'h0_0006_0000;
    b[W-1:0] = 36'h0_0008_0000;
    e[W-1:0] = 36'h0_000C_0000;
    run_one(a, b, res, o, lat);
    checks++; if (lat !== LAT) $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); else passed++;
    checks++; if (res !== e) $display("FAIL basic_result got=%h exp=%h", res, e); else passed++;
    checks++; if (o !== '0) $display("FAIL basic_ovf got=%b exp=0", o); else passed++;
    // A few random vectors through the same single-shot path.
    for (int i = 0; i < 4; i++) begin
      a = rand_vec();
      b = rand_vec();
      m = model_vec(a, b);
      run_one(a, b, res, o, lat);
      checks++; if (lat !== LAT) $display("FAIL single_latency i=%0d got=%0d exp=%0d", i, lat, LAT); else passed++;
      checks++; if ({o, res} !== m) $display("FAIL single_result i=%0d got=%h exp=%h", i, {o, res}, m); else passed++;
    end
  endtask

  task automatic test_rounding();
    logic [VW-1:0] a, b, res;
    logic [N-1:0]  o;
    int            lat;
    logic [W-1:0]  e0, e1, e2, e3;
    a = '0; b = '0;
    a[0*W +: W] = 36'h0_0000_0001; b[0*W +: W] = 36'h0_0002_0000;  // exact half LSB
    a[1*W +: W] = 36'hF_FFFC_0000; b[1*W +: W] = 36'h0_0002_0000;  // -1.0 * 0.5
    a[2*W +: W] = 36'hF_FFFF_FFFF; b[2*W +: W] = 36'h0_0002_0000;  // negative half LSB
    a[3*W +: W] = 36'h0_0000_0003; b[3*W +: W] = 36'h0_0001_0000;  // 0.75 LSB
    e0 = (RM != 0) ? 36'h0_0000_0001 : 36'h0_0000_0000;
    e1 = 36'hF_FFFE_0000;
    e2 = (RM != 0) ? 36'h0_0000_0000 : 36'hF_FFFF_FFFF;
    e3 = (RM != 0) ? 36'h0_0000_0001 : 36'h0_0000_0000;
    run_one(a, b, res, o, lat);
    checks++; if (lat !== LAT) $display("FAIL round_latency got=%0d exp=%0d", lat, LAT); else passed++;
    checks++; if (res[0*W +: W] !== e0) $display("FAIL round_half_tie got=%h exp=%h", res[0*W +: W], e0); else passed++;
    checks++; if (res[1*W +: W] !== e1) $display("FAIL round_sign got=%h exp=%h", res[1*W +: W], e1); else passed++;
    checks++; if (res[2*W +: W] !== e2) $display("FAIL round_neg_tie got=%h exp=%h", res[2*W +: W], e2); else passed++;
    checks++; if (res[3*W +: W] !== e3) $display("FAIL round_up got=%h exp=%h", res[3*W +: W], e3); else passed++;
    checks++; if (o !== '0) $display("FAIL round_ovf got=%b exp=0", o); else passed++;
  endtask

  task automatic test_overflow();
    logic [VW-1:0] a, b, res, e;
    logic [N-1:0]  o, eo;
    int            lat;
    // Largest positive squared on lane 2, other lanes zero.
    a = '0; b = '0; e = '0;
    a[2*W +: W] = 36'h7_FFFF_FFFF;
    b[2*W +: W] = 36'h7_FFFF_FFFF;
`ifdef ARRAY_MULT_PIPE_SAT_EN
    e[2*W +: W] = 36'h7_FFFF_FFFF;
    eo = 4'b0100;
`else
    e[2*W +: W] = 36'hF_FFFC_0000;
    eo = 4'b0000;
`endif
    run_one(a, b, res, o, lat);
    checks++; if (res !== e) $display("FAIL ovf_pos_result got=%h exp=%h", res, e); else passed++;
    checks++; if (o !== eo) $display("FAIL ovf_pos_flag got=%b exp=%b", o, eo); else passed++;
    // Most negative times 2.0 on lane 2; lane 0 is most negative times 1.0,
    // which lands exactly on the lower bound without overflowing.
    a = '0; b = '0; e = '0;
    a[2*W +: W] = 36'h8_0000_0000; b[2*W +: W] = 36'h0_0008_0000;
    a[0*W +: W] = 36'h8_0000_0000; b[0*W +: W] = 36'h0_0004_0000;
    e[0*W +: W] = 36'h8_0000_0000;
`ifdef ARRAY_MULT_PIPE_SAT_EN
    e[2*W +: W] = 36'h8_0000_0000;
    eo = 4'b0100;
`else
    e[2*W +: W] = 36'h0_0000_0000;
    eo = 4'b0000;
`endif
    run_one(a, b, res, o, lat);
    checks++; if (res !== e) $display("FAIL ovf_neg_result got=%h exp=%h", res, e); else passed++;
    checks++; if (o !== eo) $display("FAIL ovf_neg_flag got=%b exp=%b", o, eo); else passed++;
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] va [6];
    logic [VW-1:0] vb [6];
    logic [VW-1:0] got_r [6];
    logic [N-1:0]  got_o [6];
    logic [VW-1:0] held_r;
    logic [N-1:0]  held_o;
    logic [VW+N-1:0] m;
    logic          have_hold;
    logic          saw_stall;
    int            sent, recv;
    for (int i = 0; i < 6; i++) begin
      va[i] = rand_vec();
      vb[i] = rand_vec();
      va[i][W-1:0] = W'(i + 1);       // lane 0 tags the vector: (i+1) * 1.0
      vb[i][W-1:0] = W'(1) << F;
    end
    sent = 0; recv = 0; have_hold = 1'b0; saw_stall = 1'b0;
    held_r = '0; held_o = '0;
    for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
      @(posedge clk); #1;
      in_valid = (sent < 6);
      if (sent < 6) begin
        dataa = va[sent];
        datab = vb[sent];
      end
      out_ready = (cyc >= 8);
      @(negedge clk);
      if (out_valid && !out_ready) begin
        saw_stall = 1'b1;
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); else passed++;
        if (have_hold) begin
          checks++; if ({ovf, result} !== {held_o, held_r}) $display("FAIL bp_hold cyc=%0d got=%h exp=%h", cyc, {ovf, result}, {held_o, held_r}); else passed++;
        end else begin
          held_r    = result;
          held_o    = ovf;
          have_hold = 1'b1;
        end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        got_r[recv] = result;
        got_o[recv] = ovf;
        recv++;
      end
    end
    checks++; if (saw_stall !== 1'b1) $display("FAIL bp_stall_seen got=%b exp=1", saw_stall); else passed++;
    checks++; if (recv !== 6) $display("FAIL bp_count got=%0d exp=6", recv); else passed++;
    for (int i = 0; i < 6 && i < recv; i++) begin
      m = model_vec(va[i], vb[i]);
      checks++; if ({got_o[i], got_r[i]} !== m) $display("FAIL bp_order i=%0d got=%h exp=%h", i, {got_o[i], got_r[i]}, m); else passed++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_random();
    logic [VW+N-1:0] e;
    logic            acc_last;
    int              sent, recv, cyc;
    exp_q.delete();
    sent = 0; recv = 0; cyc = 0; acc_last = 1'b0;
    in_valid = 1'b0;
    while ((sent < NV || recv < sent) && cyc < 60000) begin
      @(posedge clk); #1;
      // A vector that was offered but not taken stays offered unchanged.
      if (!(in_valid && !acc_last)) begin
        in_valid = (sent < NV) && ($urandom_range(0, 1) == 1);
        if (in_valid) begin
          dataa = rand_vec();
          datab = rand_vec();
        end
      end
      out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      checks++; if (in_ready !== (!out_valid || out_ready)) $display("FAIL rnd_adv cyc=%0d in_ready=%b out_valid=%b out_ready=%b", cyc, in_ready, out_valid, out_ready); else passed++;
      acc_last = in_valid && in_ready;
      if (acc_last) begin
        exp_q.push_back(model_vec(dataa, datab));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rnd_unexpected cyc=%0d got=%h exp=none", cyc, {ovf, result});
        end else begin
          e = exp_q.pop_front();
          if ({ovf, result} !== e) $display("FAIL rnd_result n=%0d got=%h exp=%h", recv, {ovf, result}, e); else passed++;
        end
        recv++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (recv !== NV) $display("FAIL rnd_count got=%0d exp=%0d", recv, NV); else passed++;
    checks++; if (exp_q.size() !== 0) $display("FAIL rnd_leftover got=%0d exp=0", exp_q.size()); else passed++;
  endtask

  task automatic test_reset_midstall();
    logic [VW-1:0]   a, b, res;
    logic [N-1:0]    o;
    logic [VW+N-1:0] m;
    int              lat, stale;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      dataa    = rand_vec();
      datab    = rand_vec();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("FAIL rst_stall_setup got=%b exp=1", out_valid); else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_async_valid got=%b exp=0", out_valid); else passed++;
    checks++; if (result !== '0) $display("FAIL rst_async_result got=%h exp=0", result); else passed++;
    checks++; if (ovf !== '0) $display("FAIL rst_async_ovf got=%b exp=0", ovf); else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", in_ready); else passed++;
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) $display("FAIL rst_stale got=%0d exp=0", stale); else passed++;
    a = rand_vec();
    b = rand_vec();
    m = model_vec(a, b);
    run_one(a, b, res, o, lat);
    checks++; if (lat !== LAT) $display("FAIL rst_first_latency got=%0d exp=%0d", lat, LAT); else passed++;
    checks++; if ({o, res} !== m) $display("FAIL rst_first_result got=%h exp=%h", {o, res}, m); else passed++;
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_backpressure();
    test_random();
    test_reset_midstall();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
